// File: rtl/mux_seq_pkg.sv
// Shared types and helpers for the mux_sequenceur channel selector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_seq_pkg;

   // FSM states, one per edge action: follow sel, sweep channels, freeze.
   typedef enum logic [1:0] {
      MANUAL = 2'd0,
      SCAN   = 2'd1,
      HOLD   = 2'd2
   } state_t;

   // Encoding of the mode input.
   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Next channel in the sweep, wrapping from n_ch-1 back to 0.
   function automatic int unsigned next_ch(input int unsigned cur, input int unsigned n_ch);
      return (cur >= n_ch - 32'd1) ? 32'd0 : cur + 32'd1;
   endfunction

endpackage

// File: rtl/compteur_dwell.sv
// Dwell counter: counts enabled cycles and pulses wrap on the last cycle of a dwell period.
// Latency: wrap is combinational from the current count and en; the count updates on the edge.
// Backpressure: none; en=0 freezes the count, clr (or rst) returns it to 0.
// Ports: clk, rst (sync, active-high), en (count this edge), clr (zero this edge),
//        wrap (cnt==DWELL-1 while en=1).
module compteur_dwell
   import mux_seq_pkg::*;
#(
   parameter int DWELL = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic wrap
);

   localparam int CW = $clog2(DWELL) + 1;
   localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

   logic [CW-1:0] cnt;

   assign wrap = en && (cnt == LAST);

   // Count restarts at 0 on wrap, so it never goes past DWELL-1.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= wrap ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mux_sequenceur.sv
// Registered N_CH-way channel selector with manual select, round-robin scan and hold.
// Latency: 1 cycle from din/sel/mode/hold to z/z_valid/ch.
// Backpressure: none; hold freezes z, ch and the dwell count and drops z_valid.
// Ports: clk, rst (sync, active-high), din (packed channels, ch i at din[i*WIDTH +: WIDTH]),
//        sel (manual channel), mode (0 manual / 1 scan), hold (freeze),
//        z (selected data), z_valid (fresh in-range data this cycle), ch (channel on z).
module mux_sequenceur
   import mux_seq_pkg::*;
#(
   parameter  int WIDTH = 1,
   parameter  int N_CH  = 4,
   parameter  int DWELL = 4,
   localparam int SELW  = $clog2(N_CH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH*WIDTH-1:0]   din,
   input  logic [SELW-1:0]         sel,
   input  logic                    mode,
   input  logic                    hold,
   output logic [WIDTH-1:0]        z,
   output logic                    z_valid,
   output logic [SELW-1:0]         ch
);

   state_t            state;
   state_t            nxt_state;
   logic              wrap;
   logic              cnt_en;
   logic              cnt_clr;
   logic              sel_ok;
   logic [SELW-1:0]   scan_ch;
   logic [WIDTH-1:0]  sel_dat;
   logic [WIDTH-1:0]  scan_dat;
   logic [WIDTH-1:0]  chan [N_CH];

   for (genvar g = 0; g < N_CH; g++) begin : g_chan
      assign chan[g] = din[g*WIDTH +: WIDTH];
   end

   // The action taken at an edge is decided by the inputs present at that edge
   // (hold beats mode); state records which action was taken.
   always_comb begin
      nxt_state = MANUAL;
      if (hold) begin
         nxt_state = HOLD;
      end else if (mode == MODE_SCAN) begin
         nxt_state = SCAN;
      end
   end

   // Counter runs only while scanning and restarts whenever we are in manual,
   // so a scan entered from manual dwells a full period on the current channel.
   assign cnt_en  = !rst && (nxt_state == SCAN);
   assign cnt_clr = (nxt_state == MANUAL);

   compteur_dwell #(
      .DWELL (DWELL)
   ) u_dwell (
      .clk  (clk),
      .rst  (rst),
      .en   (cnt_en),
      .clr  (cnt_clr),
      .wrap (wrap)
   );

   // sel can exceed N_CH-1 only when N_CH is not a power of two.
   always_comb begin
      sel_ok   = (32'(sel) < 32'(N_CH));
      scan_ch  = wrap ? SELW'(next_ch(32'(ch), 32'(N_CH))) : ch;
      sel_dat  = '0;
      scan_dat = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (sel == SELW'(i)) begin
            sel_dat = chan[i];
         end
         if (scan_ch == SELW'(i)) begin
            scan_dat = chan[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= MANUAL;
         z       <= '0;
         z_valid <= 1'b0;
         ch      <= '0;
      end else begin
         state <= nxt_state;
         case (nxt_state)
            SCAN: begin
               ch      <= scan_ch;
               z       <= scan_dat;
               z_valid <= 1'b1;
            end
            MANUAL: begin
               if (sel_ok) begin
                  ch      <= sel;
                  z       <= sel_dat;
                  z_valid <= 1'b1;
               end else begin
                  z       <= '0;
                  z_valid <= 1'b0;
               end
            end
            default: begin
               // Frozen: z and ch keep their values, only freshness drops.
               z_valid <= 1'b0;
            end
         endcase
      end
   end

   // A frozen output is never flagged as fresh.
   always_ff @(posedge clk) begin
      if (!rst && state == HOLD) begin
         assert (!z_valid);
      end
   end

endmodule
